// File: rtl/segre_pkg.sv
// Shared sizes and enumerations for the segre memory-side blocks.
package segre_pkg;

   localparam int unsigned ADDR_SIZE = 32;
   localparam int unsigned LINE_SIZE = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IC = 2'd1,
      BUSY_DC = 2'd2,
      DONE    = 2'd3
   } mem_arb_state_e;

   typedef enum logic {
      GNT_IC = 1'b0,
      GNT_DC = 1'b1
   } mem_arb_grant_e;

endpackage : segre_pkg

// File: rtl/segre_rr_arb2.sv
// Two-way round-robin pick between the instruction and data caches.
module segre_rr_arb2
   import segre_pkg::*;
(
   input  logic           ic_req,
   input  logic           dc_req,
   input  mem_arb_grant_e last_grant,
   output mem_arb_grant_e grant_c
);

   // On a tie the side that did not win last time gets the memory.
   always_comb begin
      grant_c = last_grant;
      if (ic_req && dc_req) begin
         grant_c = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
      end else if (ic_req) begin
         grant_c = GNT_IC;
      end else if (dc_req) begin
         grant_c = GNT_DC;
      end
   end

endmodule : segre_rr_arb2

// File: rtl/segre_mem_arbiter.sv
// Serialises IC refills and DC refills/writebacks onto a single memory port,
// one outstanding transfer at a time.
module segre_mem_arbiter
   import segre_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_SIZE,
   parameter int unsigned LINE_W = LINE_SIZE
) (
   input  logic              clk_i,
   input  logic              rsn_i,

   input  logic              ic_req_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              ic_rsp_valid_o,
   output logic [LINE_W-1:0] ic_rdata_o,

   input  logic              dc_req_i,
   input  logic              dc_we_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [LINE_W-1:0] dc_wdata_i,
   output logic              dc_rsp_valid_o,
   output logic [LINE_W-1:0] dc_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_rdata_i
);

   mem_arb_state_e state_q, state_d;
   mem_arb_grant_e last_grant_q, gnt_q, arb_grant_c;

   logic grant_now_c;
   logic done_now_c;
   logic mem_req_d;
   logic ic_rsp_d;
   logic dc_rsp_d;

   segre_rr_arb2 u_rr_arb2 (
      .ic_req     (ic_req_i),
      .dc_req     (dc_req_i),
      .last_grant (last_grant_q),
      .grant_c    (arb_grant_c)
   );

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Requests are only looked at in IDLE, so DONE always drains back first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ic_req_i || dc_req_i) begin
               state_d = (arb_grant_c == GNT_IC) ? BUSY_IC : BUSY_DC;
            end
         end
         BUSY_IC,
         BUSY_DC: begin
            if (mem_ready_i) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs, derived from the upcoming state.
   always_comb begin
      grant_now_c = 1'b0;
      done_now_c  = 1'b0;
      mem_req_d   = 1'b0;
      ic_rsp_d    = 1'b0;
      dc_rsp_d    = 1'b0;
      grant_now_c = (state_q == IDLE) && (ic_req_i || dc_req_i);
      done_now_c  = ((state_q == BUSY_IC) || (state_q == BUSY_DC)) && mem_ready_i;
      mem_req_d   = (state_d == BUSY_IC) || (state_d == BUSY_DC);
      ic_rsp_d    = (state_d == DONE) && (gnt_q == GNT_IC);
      dc_rsp_d    = (state_d == DONE) && (gnt_q == GNT_DC);
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         last_grant_q   <= GNT_DC;
         gnt_q          <= GNT_IC;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         ic_rsp_valid_o <= 1'b0;
         dc_rsp_valid_o <= 1'b0;
         ic_rdata_o     <= '0;
         dc_rdata_o     <= '0;
      end else begin
         mem_req_o      <= mem_req_d;
         ic_rsp_valid_o <= ic_rsp_d;
         dc_rsp_valid_o <= dc_rsp_d;
         if (grant_now_c) begin
            last_grant_q <= arb_grant_c;
            gnt_q        <= arb_grant_c;
            if (arb_grant_c == GNT_IC) begin
               mem_addr_o <= ic_addr_i;
               mem_we_o   <= 1'b0;
            end else begin
               mem_addr_o  <= dc_addr_i;
               mem_we_o    <= dc_we_i;
               mem_wdata_o <= dc_wdata_i;
            end
         end
         // A writeback completion leaves dc_rdata_o untouched.
         if (done_now_c) begin
            if (gnt_q == GNT_IC) begin
               ic_rdata_o <= mem_rdata_i;
            end else if (!mem_we_o) begin
               dc_rdata_o <= mem_rdata_i;
            end
         end
      end
   end

endmodule : segre_mem_arbiter

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: latency, round-robin, writeback, reset abort.
module tb_segre_mem_arbiter;
   import segre_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 128;

   logic              clk_i = 1'b0;
   logic              rsn_i;
   logic              ic_req_i;
   logic [ADDR_W-1:0] ic_addr_i;
   logic              ic_rsp_valid_o;
   logic [LINE_W-1:0] ic_rdata_o;
   logic              dc_req_i;
   logic              dc_we_i;
   logic [ADDR_W-1:0] dc_addr_i;
   logic [LINE_W-1:0] dc_wdata_i;
   logic              dc_rsp_valid_o;
   logic [LINE_W-1:0] dc_rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic              mem_ready_i;
   logic [LINE_W-1:0] mem_rdata_i;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   localparam logic [LINE_W-1:0] D1 = 128'h1111_0000_1111_0000_1111_0000_1111_0001;
   localparam logic [LINE_W-1:0] D2 = 128'h2222_0000_2222_0000_2222_0000_2222_0002;
   localparam logic [LINE_W-1:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
   localparam logic [LINE_W-1:0] D4 = 128'h4444_0000_4444_0000_4444_0000_4444_0004;
   localparam logic [LINE_W-1:0] D5 = 128'h5555_0000_5555_0000_5555_0000_5555_0005;
   localparam logic [LINE_W-1:0] WB = {16{8'hA5}};

   segre_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk_i          (clk_i),
      .rsn_i          (rsn_i),
      .ic_req_i       (ic_req_i),
      .ic_addr_i      (ic_addr_i),
      .ic_rsp_valid_o (ic_rsp_valid_o),
      .ic_rdata_o     (ic_rdata_o),
      .dc_req_i       (dc_req_i),
      .dc_we_i        (dc_we_i),
      .dc_addr_i      (dc_addr_i),
      .dc_wdata_i     (dc_wdata_i),
      .dc_rsp_valid_o (dc_rsp_valid_o),
      .dc_rdata_o     (dc_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_ready_i    (mem_ready_i),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rsn_i = 1'b0;
      step();
      step();
      rsn_i = 1'b1;
   endtask

   initial begin
      rsn_i = 1'b0; ic_req_i = 1'b0; ic_addr_i = '0; dc_req_i = 1'b0; dc_we_i = 1'b0;
      dc_addr_i = '0; dc_wdata_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
      step();
      chk("rst_mem_req", 128'(mem_req_o), 128'(0));
      chk("rst_mem_we", 128'(mem_we_o), 128'(0));
      chk("rst_mem_addr", 128'(mem_addr_o), 128'(0));
      chk("rst_mem_wdata", mem_wdata_o, '0);
      chk("rst_ic_rsp", 128'(ic_rsp_valid_o), 128'(0));
      chk("rst_dc_rsp", 128'(dc_rsp_valid_o), 128'(0));
      chk("rst_ic_rdata", ic_rdata_o, '0);
      chk("rst_dc_rdata", dc_rdata_o, '0);
      rsn_i = 1'b1;
      step();

      // IC alone, memory ready on the first busy cycle
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_1000; mem_ready_i = 1'b1; mem_rdata_i = D1;
      step();
      ic_req_i = 1'b0;
      chk("t1_busy_req", 128'(mem_req_o), 128'(1));
      chk("t1_addr", 128'(mem_addr_o), 128'(32'h1000));
      chk("t1_we", 128'(mem_we_o), 128'(0));
      chk("t1_busy_rsp", 128'(ic_rsp_valid_o), 128'(0));
      step();
      chk("t1_done_rsp", 128'(ic_rsp_valid_o), 128'(1));
      chk("t1_done_req", 128'(mem_req_o), 128'(0));
      chk("t1_rdata", ic_rdata_o, D1);
      step();
      chk("t1_rsp_end", 128'(ic_rsp_valid_o), 128'(0));
      mem_ready_i = 1'b0;

      // Tie after reset: IC, then DC, then IC again
      do_reset();
      ic_req_i = 1'b1; dc_req_i = 1'b1; ic_addr_i = 32'h100; dc_addr_i = 32'h200;
      dc_we_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = D2;
      step();
      chk("t2_first_addr", 128'(mem_addr_o), 128'(32'h100));
      step();
      chk("t2_ic_rsp", 128'(ic_rsp_valid_o), 128'(1));
      chk("t2_ic_rdata", ic_rdata_o, D2);
      chk("t2_done_no_dc", 128'(dc_rsp_valid_o), 128'(0));
      mem_rdata_i = D3;
      step();
      chk("t2_idle_no_req", 128'(mem_req_o), 128'(0));
      chk("t2_idle_no_ic", 128'(ic_rsp_valid_o), 128'(0));
      step();
      chk("t2_dc_req", 128'(mem_req_o), 128'(1));
      chk("t2_dc_addr", 128'(mem_addr_o), 128'(32'h200));
      step();
      chk("t2_dc_rsp", 128'(dc_rsp_valid_o), 128'(1));
      chk("t2_dc_rdata", dc_rdata_o, D3);
      chk("t2_ic_hold", ic_rdata_o, D2);
      step();
      chk("t2_idle2", 128'(mem_req_o), 128'(0));
      step();
      chk("t2_again_ic", 128'(mem_addr_o), 128'(32'h100));
      ic_req_i = 1'b0; dc_req_i = 1'b0;
      mem_rdata_i = D2;
      step();
      chk("t2_again_rsp", 128'(ic_rsp_valid_o), 128'(1));
      mem_ready_i = 1'b0;
      step();

      // DC writeback with five memory wait cycles
      dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h2040; dc_wdata_i = WB; mem_rdata_i = D4;
      step();
      dc_req_i = 1'b0; dc_wdata_i = '0; dc_addr_i = '0; dc_we_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("t3_req", 128'(mem_req_o), 128'(1));
         chk("t3_we", 128'(mem_we_o), 128'(1));
         chk("t3_addr", 128'(mem_addr_o), 128'(32'h2040));
         chk("t3_wdata", mem_wdata_o, WB);
         chk("t3_no_rsp", 128'(dc_rsp_valid_o), 128'(0));
         if (i == 5) mem_ready_i = 1'b1;
         step();
      end
      mem_ready_i = 1'b0;
      chk("t3_rsp", 128'(dc_rsp_valid_o), 128'(1));
      chk("t3_req_drop", 128'(mem_req_o), 128'(0));
      chk("t3_rdata_hold", dc_rdata_o, D3);
      step();
      chk("t3_rsp_once", 128'(dc_rsp_valid_o), 128'(0));
      chk("t3_rdata_hold2", dc_rdata_o, D3);

      // Reset during BUSY_DC
      dc_req_i = 1'b1; dc_addr_i = 32'h3000; mem_rdata_i = D5;
      step();
      dc_req_i = 1'b0;
      chk("t4_busy", 128'(mem_req_o), 128'(1));
      #2 rsn_i = 1'b0;
      #1;
      chk("t4_async_drop", 128'(mem_req_o), 128'(0));
      mem_ready_i = 1'b1;
      step();
      chk("t4_no_rsp", 128'(dc_rsp_valid_o), 128'(0));
      rsn_i = 1'b1;
      step();
      chk("t4_state_idle", 128'(dut.state_q), 128'(IDLE));
      chk("t4_no_rsp2", 128'(dc_rsp_valid_o), 128'(0));
      chk("t4_rdata_clr", dc_rdata_o, '0);
      step();
      chk("t4_ready_ignored", 128'(dc_rsp_valid_o | ic_rsp_valid_o), 128'(0));
      mem_ready_i = 1'b0;

      // IC drops req mid-transfer
      ic_req_i = 1'b1; ic_addr_i = 32'h4000; mem_rdata_i = D5;
      step();
      ic_req_i = 1'b0;
      chk("t5_busy", 128'(mem_req_o), 128'(1));
      step();
      chk("t5_still_busy", 128'(mem_req_o), 128'(1));
      chk("t5_no_rsp", 128'(ic_rsp_valid_o), 128'(0));
      mem_ready_i = 1'b1;
      step();
      mem_ready_i = 1'b0;
      chk("t5_rsp", 128'(ic_rsp_valid_o), 128'(1));
      chk("t5_rdata", ic_rdata_o, D5);
      step();
      chk("t5_rsp_once", 128'(ic_rsp_valid_o), 128'(0));
      chk("t5_idle", 128'(mem_req_o), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_segre_mem_arbiter

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default ADDR_SIZE (32), memory byte-address width.
REQ-002 The block SHALL have parameter LINE_W, default LINE_SIZE (128), cache line width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk_i  in  1  clock; rsn_i  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these instruction-cache ports:
- ic_req_i  in  1  IC line-refill read request
- ic_addr_i  in  ADDR_W  IC line address
- ic_rsp_valid_o  out  1  one-cycle IC completion pulse
- ic_rdata_o  out  LINE_W  IC refill line
REQ-005 The block SHALL have these data-cache ports:
- dc_req_i  in  1  DC request
- dc_we_i  in  1  1 = writeback, 0 = refill
- dc_addr_i  in  ADDR_W  DC line address
- dc_wdata_i  in  LINE_W  writeback line
- dc_rsp_valid_o  out  1  one-cycle DC completion pulse
- dc_rdata_o  out  LINE_W  DC refill line
REQ-006 The block SHALL have these memory ports:
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  LINE_W  memory write data
- mem_ready_i  in  1  memory transfer done; mem_rdata_i valid this cycle
- mem_rdata_i  in  LINE_W  memory read line

Function
REQ-007 The FSM SHALL have states IDLE, BUSY_IC, BUSY_DC and DONE.
REQ-008 In IDLE with exactly one request asserted, the FSM SHALL grant that requester and go to BUSY_IC or BUSY_DC.
REQ-009 In IDLE with both requests asserted, the FSM SHALL grant the requester not recorded in last_grant (round-robin).
REQ-010 On every grant, last_grant SHALL be updated to the granted requester.
REQ-011 On grant, the block SHALL latch the granted address, and for DC also we and wdata, into registers that drive mem_addr_o, mem_we_o and mem_wdata_o.
REQ-012 For IC grants, mem_we_o SHALL be 0.
REQ-013 In BUSY_*, mem_req_o SHALL be 1 and mem_addr_o, mem_we_o and mem_wdata_o SHALL stay stable until mem_ready_i=1.
REQ-014 In BUSY_* with mem_ready_i=1, the block SHALL register mem_rdata_i into the granted requester's rdata output and go to DONE.
REQ-015 In BUSY_*, mem_req_o SHALL be deasserted in the cycle after mem_ready_i.
REQ-016 mem_ready_i SHALL be ignored outside BUSY_* states.
REQ-017 In DONE, the block SHALL pulse the granted requester's rsp_valid_o for exactly one cycle, then return unconditionally to IDLE.
REQ-018 Requester req inputs SHALL be ignored while the FSM is in DONE.
REQ-019 For a DC writeback, dc_rsp_valid_o SHALL pulse and dc_rdata_o SHALL hold its previous value.
REQ-020 The minimum latency from req sampled in IDLE to rsp_valid_o SHALL be 2 cycles: IDLE, then BUSY with mem_ready_i=1, then DONE.
REQ-021 Memory wait cycles SHALL add one cycle each to that latency.
REQ-022 A requester dropping req in mid-transaction SHALL be ignored: the transaction completes and rsp_valid_o still pulses.
REQ-023 ic_rdata_o and dc_rdata_o SHALL hold their values until that requester's next completed read.
REQ-024 The block SHALL have at most one outstanding memory transaction, and a new grant SHALL only occur in IDLE.

Reset
REQ-025 While rsn_i=0, the FSM SHALL be in IDLE.
REQ-026 While rsn_i=0, all outputs and latched registers SHALL be 0.
REQ-027 While rsn_i=0, last_grant SHALL equal DC, so IC wins the first tie.
REQ-028 Reset asserted mid-transaction SHALL drop mem_req_o immediately (asynchronously), abandon the transfer, and produce no rsp_valid_o pulse.

Structure
REQ-029 segre_pkg SHALL hold LINE_SIZE, mem_arb_state_e {IDLE, BUSY_IC, BUSY_DC, DONE} and mem_arb_grant_e {GNT_IC, GNT_DC}.
REQ-030 The two-way round-robin pick SHALL be the sole sub-module, segre_rr_arb2, with inputs ic_req, dc_req and last_grant and output the combinational grant.

Verification
REQ-031 A bench SHALL drive IC req alone at addr 0x0000_1000 with mem_ready_i=1 on the first BUSY cycle, and check: mem_addr_o=0x1000, mem_we_o=0, ic_rsp_valid_o 2 cycles after the req is sampled, and ic_rdata_o equal to mem_rdata_i.
REQ-032 A bench SHALL drive IC and DC req simultaneously after reset, and check: IC served first, DC granted at the next IDLE; then, with both re-requested, IC granted first again because last_grant=DC.
REQ-033 A bench SHALL drive a DC writeback to addr 0x2040 with wdata 0xA5..A5 and mem_ready_i delayed 5 cycles, and check: mem_req_o, mem_we_o=1, mem_addr_o and mem_wdata_o stable for 6 cycles, dc_rsp_valid_o pulsing once, and dc_rdata_o unchanged.
REQ-034 A bench SHALL assert rsn_i=0 during BUSY_DC, and check: mem_req_o=0 immediately, no dc_rsp_valid_o pulse, and the FSM in IDLE after release.
REQ-035 A bench SHALL have IC drop req in mid-BUSY_IC, and check: the transfer completes and ic_rsp_valid_o pulses once.
REQ-036 A bench SHALL hold req asserted through DONE, and check that no second grant occurs before IDLE is reached.
